// File: rtl/cic_comp_fir_if.sv
// Sample/coefficient/status bundle between the CIC decimator, the
// compensation FIR and the demod path.
interface cic_comp_fir_if #(
    parameter int TAPS      = 16,
    parameter int COEF_BITS = 12,
    parameter int DATA_BITS = 16
);
    localparam int AW = $clog2(TAPS);

    logic                        in_tick;
    logic signed [DATA_BITS-1:0] x_in;
    logic                        coef_we;
    logic [AW-1:0]               coef_addr;
    logic signed [COEF_BITS-1:0] coef_data;
    logic signed [DATA_BITS-1:0] x_out;
    logic                        out_tick;
    logic                        busy;
    logic                        overrun;

    modport master (
        output in_tick, x_in, coef_we, coef_addr, coef_data,
        input  x_out, out_tick, busy, overrun
    );

    modport slave (
        input  in_tick, x_in, coef_we, coef_addr, coef_data,
        output x_out, out_tick, busy, overrun
    );
endinterface

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: one time-shared multiplier walks TAPS taps per
// input sample over a circular sample buffer, then rounds and saturates.
module cic_comp_fir #(
    parameter int TAPS      = 16,
    parameter int COEF_BITS = 12,
    parameter int DATA_BITS = 16,
    parameter int ACC_WIDTH = DATA_BITS + COEF_BITS + $clog2(TAPS)
) (
    input  logic          CLK,
    input  logic          RST,
    cic_comp_fir_if.slave bus
);
    localparam int AW = $clog2(TAPS);
    localparam int PW = DATA_BITS + COEF_BITS;
    localparam int SH = COEF_BITS - 2;
    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
    localparam logic signed [COEF_BITS-1:0] C_ONE = {2'b01, {SH{1'b0}}};
    localparam logic signed [ACC_WIDTH:0] RND =
        {{(ACC_WIDTH - COEF_BITS + 3){1'b0}}, 1'b1, {(COEF_BITS - 3){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] SAT_HI =
        {{(ACC_WIDTH - DATA_BITS + 2){1'b0}}, {(DATA_BITS - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_LO =
        {{(ACC_WIDTH - DATA_BITS + 2){1'b1}}, {(DATA_BITS - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

    state_t state, state_nxt;

    logic signed [DATA_BITS-1:0] buf_q  [TAPS];
    logic signed [COEF_BITS-1:0] coef_q [TAPS];
    logic [AW-1:0]               wr_ptr, rd_ptr, k;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [DATA_BITS-1:0] hold_q, x_out_q;
    logic                        hold_full, out_tick_q, overrun_q;

    logic                        idle, start, hold_load, hold_take, drop;
    logic signed [DATA_BITS-1:0] start_data, y_sat;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH:0]   rnd_sum, rnd_shr;

    assign idle       = (state == S_IDLE);
    // A held sample is older than anything arriving now, so it goes first.
    assign start      = idle && (hold_full || bus.in_tick);
    assign start_data = hold_full ? hold_q : bus.x_in;
    assign hold_take  = idle && hold_full;
    assign hold_load  = bus.in_tick && (idle ? hold_full : !hold_full);
    assign drop       = bus.in_tick && !idle && hold_full;

    assign prod = PW'(coef_q[k]) * PW'(buf_q[rd_ptr]);

    always_comb begin
        rnd_sum = $signed({acc[ACC_WIDTH-1], acc}) + RND;
        rnd_shr = rnd_sum >>> SH;
        if (rnd_shr > SAT_HI)
            y_sat = {1'b0, {(DATA_BITS - 1){1'b1}}};
        else if (rnd_shr < SAT_LO)
            y_sat = {1'b1, {(DATA_BITS - 1){1'b0}}};
        else
            y_sat = rnd_shr[DATA_BITS-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_MAC;
            S_MAC:   if (k == K_LAST) state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            k          <= '0;
            acc        <= '0;
            hold_q     <= '0;
            hold_full  <= 1'b0;
            x_out_q    <= '0;
            out_tick_q <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                buf_q[i]  <= '0;
                coef_q[i] <= (i == 0) ? C_ONE : '0;
            end
        end else begin
            out_tick_q <= (state == S_ROUND);
            if (state == S_ROUND) x_out_q <= y_sat;

            // rd_ptr starts on the slot being written (newest) and walks back.
            if (start) begin
                buf_q[wr_ptr] <= start_data;
                wr_ptr        <= (wr_ptr == K_LAST) ? '0 : wr_ptr + 1'b1;
                rd_ptr        <= wr_ptr;
                k             <= '0;
                acc           <= '0;
            end else if (state == S_MAC) begin
                acc    <= acc + ACC_WIDTH'(prod);
                rd_ptr <= (rd_ptr == '0) ? K_LAST : rd_ptr - 1'b1;
                k      <= k + 1'b1;
            end

            if (hold_load) begin
                hold_q    <= bus.x_in;
                hold_full <= 1'b1;
            end else if (hold_take) begin
                hold_full <= 1'b0;
            end

            if (drop) overrun_q <= 1'b1;

            for (int i = 0; i < TAPS; i++)
                if (bus.coef_we && idle && bus.coef_addr == AW'(i))
                    coef_q[i] <= bus.coef_data;
        end
    end

    assign bus.x_out    = x_out_q;
    assign bus.out_tick = out_tick_q;
    assign bus.busy     = !idle;
    assign bus.overrun  = overrun_q;
endmodule
